// File: rtl/spart_pkg.sv
// Shared serial-frame definitions for the SPART RX/TX blocks and the terminal model.
package spart_pkg;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_START,
    ST_BITS,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable by a sync clear.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: restart on clear, wrap at the end of each bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Tick marks the last cycle of a bit period; the FSM changes bit on this edge.
  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/terminal_tx.sv
// Serial terminal model: sends a fixed 8N1 byte message on an idle-high line.
module terminal_tx
  import spart_pkg::*;
#(
  parameter int                     CLKS_PER_BIT = 16,
  parameter int                     NUM_BYTES    = 4,
  parameter logic [NUM_BYTES*8-1:0] MSG          = {8'h0A, 8'h0D, 8'h69, 8'h48},
  parameter int                     START_DELAY  = 32,
  parameter int                     GAP_BITS     = 2,
  parameter int                     REPEAT       = 0
) (
  input  logic clk,
  input  logic rst,
  output logic data,
  output logic done
);

  localparam int BYTE_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS);
  // Message padded to a power-of-two byte count so {byte, bit} indexes it directly.
  localparam int PAD_W   = DATA_BITS << BYTE_W;
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX = (START_DELAY > GAP_CYC) ? START_DELAY : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PAD_W-1:0]  MSG_PAD   = PAD_W'(MSG);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              data_q, data_d;
  logic              done_q, done_d;
  logic              tick;
  logic              clr;
  logic              adv;

  // The bit timer restarts on every state change, so each state gets whole bit periods.
  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk),
    .rst_ni(rst),
    .clr_i (clr),
    .tick_o(tick)
  );

  // Next-state, indices, cycle counter and the line value for the coming cycle.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    adv     = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_W'(START_DELAY)) state_d = ST_START;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_BITS;
          bit_d   = '0;
        end
      end
      ST_BITS: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (GAP_BITS > 0) begin
            state_d = ST_GAP;
          end else begin
            adv = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) adv = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    // Next-byte decision after a stop bit and its gap.
    if (adv) begin
      if (byte_q != LAST_BYTE) begin
        byte_d  = byte_q + 1'b1;
        state_d = ST_START;
      end else if (REPEAT != 0) begin
        byte_d  = '0;
        state_d = ST_START;
      end else begin
        state_d = ST_DONE;
      end
    end

    clr = (state_d != state_q);

    // The cycle counter only runs in the idle-delay states and zeroes on any state change.
    cnt_d = '0;
    if (!clr && ((state_q == ST_WAIT) || (state_q == ST_GAP))) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_d)
      ST_START: data_d = ~LINE_IDLE;
      ST_BITS:  data_d = MSG_PAD[{byte_d, bit_d}];
      default:  data_d = LINE_IDLE;
    endcase

    // done follows the DONE state by one cycle.
    done_d = (state_q == ST_DONE);
  end

  // State, indices and registered outputs; reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT;
      byte_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      data_q  <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign data = data_q;
  assign done = done_q;

endmodule

// File: tb/tb_terminal_tx.sv
// Bench for terminal_tx: default message instance plus a single-byte repeating instance.
module tb_terminal_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic data_a, done_a, data_b, done_b;

  terminal_tx u_a (
    .clk (clk),
    .rst (rst_n),
    .data(data_a),
    .done(done_a)
  );

  terminal_tx #(
    .CLKS_PER_BIT(16),
    .NUM_BYTES   (1),
    .MSG         (8'hA5),
    .START_DELAY (32),
    .GAP_BITS    (0),
    .REPEAT      (1)
  ) u_b (
    .clk (clk),
    .rst (rst_n),
    .data(data_b),
    .done(done_b)
  );

  // Rising edges seen with reset released; 1 on the first such edge.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference 8N1 receiver on the default instance, sampling at bit centres.
  logic       dec_busy;
  logic       dec_ferr;
  int         dec_st;
  int         dec_n;
  logic [7:0] dec_sh;
  logic [7:0] dec_bytes[16];
  int         dec_starts[16];

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_busy <= 1'b0;
      dec_n    <= 0;
      dec_ferr <= 1'b0;
    end else if (!dec_busy) begin
      if (data_a == 1'b0) begin
        dec_busy <= 1'b1;
        dec_st   <= cyc;
      end
    end else begin
      if (((cyc - dec_st) % 16) == 8 && (cyc - dec_st) >= 24 && (cyc - dec_st) <= 136)
        dec_sh <= {data_a, dec_sh[7:1]};
      if ((cyc - dec_st) == 152) begin
        dec_busy <= 1'b0;
        if (data_a != 1'b1) dec_ferr <= 1'b1;
        if (dec_n < 16) begin
          dec_bytes[dec_n]  <= dec_sh;
          dec_starts[dec_n] <= dec_st;
        end
        dec_n <= dec_n + 1;
      end
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit   rst_before;
    bit   dut_b;
    int   cyc;
    logic exp_data;
    logic exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit b, input int c, input logic d, input logic dn);
    vec_t v;
    v.rst_before = r;
    v.dut_b      = b;
    v.cyc        = c;
    v.exp_data   = d;
    v.exp_done   = dn;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_data_a", data_a, 1'b1);
      check("rst_done_a", done_a, 1'b0);
      check("rst_data_b", data_b, 1'b1);
      check("rst_done_b", done_b, 1'b0);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    logic ad, an;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].rst_before) do_reset();
      while (cyc < vecs[i].cyc) @(negedge clk);
      ad = vecs[i].dut_b ? data_b : data_a;
      an = vecs[i].dut_b ? done_b : done_a;
      check($sformatf("vec%0d_%s_data@%0d", i, vecs[i].dut_b ? "b" : "a", cyc), ad, vecs[i].exp_data);
      check($sformatf("vec%0d_%s_done@%0d", i, vecs[i].dut_b ? "b" : "a", cyc), an, vecs[i].exp_done);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         a_last, bad_hold, waited;
    logic [7:0] exp_msg[4];
    exp_msg[0] = 8'h48; exp_msg[1] = 8'h69; exp_msg[2] = 8'h0D; exp_msg[3] = 8'h0A;

    // Default instance: idle delay, first frame (0x48), later frame bits, done timing.
    add(1, 0,   1, 1, 0);
    add(0, 0,  32, 1, 0);
    add(0, 0,  33, 0, 0);
    add(0, 0,  41, 0, 0);
    add(0, 0,  48, 0, 0);
    add(0, 0,  57, 0, 0);
    add(0, 0,  73, 0, 0);
    add(0, 0,  89, 0, 0);
    add(0, 0, 105, 1, 0);
    add(0, 0, 121, 0, 0);
    add(0, 0, 137, 0, 0);
    add(0, 0, 153, 1, 0);
    add(0, 0, 169, 0, 0);
    add(0, 0, 185, 1, 0);
    add(0, 0, 192, 1, 0);
    add(0, 0, 193, 1, 0);
    add(0, 0, 224, 1, 0);
    add(0, 0, 225, 0, 0);
    add(0, 0, 249, 1, 0);
    add(0, 0, 265, 0, 0);
    add(0, 0, 297, 1, 0);
    add(0, 0, 473, 1, 0);
    add(0, 0, 633, 0, 0);
    add(0, 0, 649, 1, 0);
    add(0, 0, 801, 1, 0);
    add(0, 0, 802, 1, 1);
    a_last = vecs.size() - 1;

    // Single-byte repeating instance: 0xA5 back-to-back every 160 cycles.
    add(1, 1,   32, 1, 0);
    add(0, 1,   33, 0, 0);
    add(0, 1,   57, 1, 0);
    add(0, 1,   73, 0, 0);
    add(0, 1,   89, 1, 0);
    add(0, 1,  169, 1, 0);
    add(0, 1,  185, 1, 0);
    add(0, 1,  192, 1, 0);
    add(0, 1,  193, 0, 0);
    add(0, 1,  353, 0, 0);
    add(0, 1,  441, 0, 0);
    add(0, 1,  457, 1, 0);
    add(0, 1, 1000, 0, 0);

    run_vecs(0, a_last);

    // Whole message decoded in order at a 192-cycle pitch with valid stop bits.
    check("dec_count", dec_n, 4);
    check("dec_ferr", dec_ferr, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dec_byte%0d", k), dec_bytes[k], exp_msg[k]);
      check($sformatf("dec_start%0d", k), dec_starts[k], 33 + 192 * k);
    end

    // Line stays idle with done high for 1000 further cycles.
    bad_hold = 0;
    repeat (1000) begin
      @(negedge clk);
      if (data_a !== 1'b1 || done_a !== 1'b1) bad_hold++;
    end
    check("hold_after_done_bad_cycles", bad_hold, 0);

    run_vecs(a_last + 1, vecs.size() - 1);

    // Reset in the middle of byte 1 (data low during its bit 1).
    do_reset();
    while (cyc < 264) @(negedge clk);
    check("mid_before_data", data_a, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_async_data", data_a, 1'b1);
    check("mid_async_done", done_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    while (dec_n < 1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("mid_restart_timeout", (dec_n >= 1), 1'b1);
    check("mid_restart_byte", dec_bytes[0], 8'h48);
    check("mid_restart_start", dec_starts[0], 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
